// File: rtl/mul_pkg.sv
// Shared constants and parameter checks for the pipelined multiplier.
package mul_pkg;

    localparam logic MUL_UNSIGNED = 1'b0;
    localparam logic MUL_SIGNED   = 1'b1;

    localparam int MUL_STAGES = 3;

    // Groups must tile the multiplier evenly and be a power of two.
    function automatic bit mul_params_ok(input int width, input int groups);
        return (groups > 0) && ((width % groups) == 0) && ((groups & (groups - 1)) == 0);
    endfunction

endpackage

// File: rtl/mul_pipe_slice.sv
// One valid/ready register stage: holds its payload while stalled, drops it on flush.
module mul_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         dn_valid_o,
    input  logic         dn_ready_i,
    output logic [W-1:0] dn_data_o
);

    logic         valid_q;
    logic         valid_d;
    logic         load;
    logic [W-1:0] data_q;

    // Ready when empty or when the current occupant leaves this cycle.
    assign up_ready_o = !valid_q || dn_ready_i;
    assign load       = up_ready_o && up_valid_i && !flush_i;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (up_ready_o) begin
            valid_d = up_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= up_data_i;
            end
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

endmodule

// File: rtl/mul_pipe.sv
// Three-stage valid/ready multiplier: operand capture, grouped partial sums, final sum.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUPS = 4,
    parameter int TAG_W  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    input  logic                 in_signed_i,
    input  logic [TAG_W-1:0]     in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_y_o,
    output logic [TAG_W-1:0]     out_tag_o,
    output logic                 busy_o
);

    localparam int PW   = 2 * WIDTH;
    localparam int GW   = WIDTH / GROUPS;
    localparam int S1_W = 2 * WIDTH + 1 + TAG_W;
    localparam int S2_W = GROUPS * PW + TAG_W;
    localparam int S3_W = PW + TAG_W;

    if (!mul_params_ok(WIDTH, GROUPS) || WIDTH < 8 || WIDTH > 64 || TAG_W < 1 || TAG_W > 16)
    begin : g_param_check
        $error("mul_pipe: illegal WIDTH=%0d GROUPS=%0d TAG_W=%0d", WIDTH, GROUPS, TAG_W);
    end

    logic                  s1_valid, s1_ready;
    logic                  s2_valid, s2_ready;
    logic                  s3_valid, s3_ready;
    logic [S1_W-1:0]       s1_in, s1_q;
    logic [S2_W-1:0]       s2_in, s2_q;
    logic [S3_W-1:0]       s3_in, s3_q;
    logic [MUL_STAGES-1:0] stage_valid;

    // ---------------- S1: operand capture ----------------
    assign s1_in      = {in_tag_i, in_signed_i, in_b_i, in_a_i};
    assign in_ready_o = s1_ready && !flush_i;

    mul_pipe_slice #(.W(S1_W)) u_s1 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .up_valid_i (in_valid_i),
        .up_ready_o (s1_ready),
        .up_data_i  (s1_in),
        .dn_valid_o (s1_valid),
        .dn_ready_i (s2_ready),
        .dn_data_o  (s1_q)
    );

    logic [WIDTH-1:0]    s1_a, s1_b;
    logic                s1_sgn;
    logic [TAG_W-1:0]    s1_tag;
    logic                a_sign;
    logic [PW-1:0]       a_ext;
    logic [WIDTH*PW-1:0] pp_flat;

    assign s1_a   = s1_q[WIDTH-1:0];
    assign s1_b   = s1_q[2*WIDTH-1:WIDTH];
    assign s1_sgn = s1_q[2*WIDTH];
    assign s1_tag = s1_q[S1_W-1 -: TAG_W];
    assign a_sign = (s1_sgn != MUL_UNSIGNED) && s1_a[WIDTH-1];
    assign a_ext  = {{WIDTH{a_sign}}, s1_a};

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
        if (gi == WIDTH - 1) begin : g_msb
            // A signed multiplier's top bit has weight -2^(WIDTH-1), so its row is negated.
            assign pp_flat[gi*PW +: PW] = !s1_b[gi] ? '0 :
                                          (s1_sgn == MUL_SIGNED) ? (~(a_ext << gi)) + PW'(1) :
                                          (a_ext << gi);
        end else begin : g_row
            assign pp_flat[gi*PW +: PW] = s1_b[gi] ? (a_ext << gi) : '0;
        end
    end

    // ---------------- S2: grouped partial sums ----------------
    for (gi = 0; gi < GROUPS; gi++) begin : g_grp
        logic [PW-1:0] grp_d;
        always_comb begin
            grp_d = '0;
            for (int k = 0; k < GW; k++) begin
                grp_d = grp_d + pp_flat[(gi*GW + k)*PW +: PW];
            end
        end
        assign s2_in[gi*PW +: PW] = grp_d;
    end
    assign s2_in[S2_W-1 -: TAG_W] = s1_tag;

    mul_pipe_slice #(.W(S2_W)) u_s2 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .up_valid_i (s1_valid),
        .up_ready_o (s2_ready),
        .up_data_i  (s2_in),
        .dn_valid_o (s2_valid),
        .dn_ready_i (s3_ready),
        .dn_data_o  (s2_q)
    );

    // ---------------- S3: final product ----------------
    logic [PW-1:0] prod_d;

    always_comb begin
        prod_d = '0;
        for (int g = 0; g < GROUPS; g++) begin
            prod_d = prod_d + s2_q[g*PW +: PW];
        end
    end

    assign s3_in = {s2_q[S2_W-1 -: TAG_W], prod_d};

    mul_pipe_slice #(.W(S3_W)) u_s3 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .up_valid_i (s2_valid),
        .up_ready_o (s3_ready),
        .up_data_i  (s3_in),
        .dn_valid_o (s3_valid),
        .dn_ready_i (out_ready_i),
        .dn_data_o  (s3_q)
    );

    assign out_valid_o = s3_valid;
    assign out_y_o     = s3_q[PW-1:0];
    assign out_tag_o   = s3_q[S3_W-1 -: TAG_W];
    assign stage_valid = {s3_valid, s2_valid, s1_valid};
    assign busy_o      = |stage_valid;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench: three multiplier widths driven in lockstep against an arithmetic reference.
module tb_mul_pipe;

    typedef struct packed {
        logic [31:0]  y16;
        logic [63:0]  y32;
        logic [127:0] y64;
        logic [4:0]   tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b1;
    logic        rand_bp = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic [4:0]  tag_in = '0;

    logic         in_ready16, in_ready32, in_ready64;
    logic         out_valid16, out_valid32, out_valid64;
    logic         busy16, busy32, busy64;
    logic [31:0]  out_y16;
    logic [63:0]  out_y32;
    logic [127:0] out_y64;
    logic [4:0]   out_tag16, out_tag32, out_tag64;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_pipe #(.WIDTH(16), .GROUPS(2), .TAG_W(5)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready16),
        .in_a_i(a_in[15:0]), .in_b_i(b_in[15:0]), .in_signed_i(in_signed), .in_tag_i(tag_in),
        .out_valid_o(out_valid16), .out_ready_i(out_ready), .out_y_o(out_y16), .out_tag_o(out_tag16),
        .busy_o(busy16)
    );

    mul_pipe #(.WIDTH(32), .GROUPS(4), .TAG_W(5)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .in_a_i(a_in[31:0]), .in_b_i(b_in[31:0]), .in_signed_i(in_signed), .in_tag_i(tag_in),
        .out_valid_o(out_valid32), .out_ready_i(out_ready), .out_y_o(out_y32), .out_tag_o(out_tag32),
        .busy_o(busy32)
    );

    mul_pipe #(.WIDTH(64), .GROUPS(8), .TAG_W(5)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready64),
        .in_a_i(a_in), .in_b_i(b_in), .in_signed_i(in_signed), .in_tag_i(tag_in),
        .out_valid_o(out_valid64), .out_ready_i(out_ready), .out_y_o(out_y64), .out_tag_o(out_tag64),
        .busy_o(busy64)
    );

    // Reference: extend each operand to a 128-bit integer, multiply, keep the low 2*w bits.
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic sgn, input int w);
        logic [127:0] ea, eb, mask;
        mask = (128'd1 << (2 * w)) - 128'd1;
        ea   = {64'd0, a} & ((128'd1 << w) - 128'd1);
        eb   = {64'd0, b} & ((128'd1 << w) - 128'd1);
        if (sgn && ea[w-1]) ea = ea - (128'd1 << w);
        if (sgn && eb[w-1]) eb = eb - (128'd1 << w);
        return (ea * eb) & mask;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic [4:0] t, output logic acc);
        logic [127:0] r;
        exp_t         e;
        in_valid  = v;
        a_in      = a;
        b_in      = b;
        in_signed = s;
        tag_in    = t;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = v && in_ready32;
        @(posedge clk);
        if (acc) begin
            r     = ref_mul(a, b, s, 16);
            e.y16 = r[31:0];
            r     = ref_mul(a, b, s, 32);
            e.y32 = r[63:0];
            e.y64 = ref_mul(a, b, s, 64);
            e.tag = t;
            exp_q.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_busy16", busy16, 1'b0);
        chk("drain_busy32", busy32, 1'b0);
        chk("drain_busy64", busy64, 1'b0);
    endtask

    // Monitor: compare every delivered result and hold-stability under stall.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_y = '0;
    logic [4:0]  prev_tag = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_out_valid", out_valid32, 1'b1);
                chk("stall_out_y", out_y32, prev_y);
                chk("stall_out_tag", out_tag32, prev_tag);
            end
            if (out_valid32 && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tag 0x%0h y 0x%0h, expected no output",
                             out_tag32, out_y32);
                end else begin
                    chk("out_valid_w16", out_valid16, 1'b1);
                    chk("out_valid_w64", out_valid64, 1'b1);
                    chk("out_y_w16", out_y16, exp_q[0].y16);
                    chk("out_y_w32", out_y32, exp_q[0].y32);
                    chk("out_y_w64", out_y64, exp_q[0].y64);
                    chk("out_tag_w16", out_tag16, exp_q[0].tag);
                    chk("out_tag_w32", out_tag32, exp_q[0].tag);
                    chk("out_tag_w64", out_tag64, exp_q[0].tag);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall <= out_valid32 && !out_ready && !flush;
            prev_y     <= out_y32;
            prev_tag   <= out_tag32;
        end
    end

    localparam logic [63:0] DIR_A [6] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                                          64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                                          64'h0, 64'h8000_0000_0000_0000};
    localparam logic [63:0] DIR_B [6] = '{64'h3, 64'h3, 64'hFFFF_FFFF_8000_0000,
                                          64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
                                          64'h8000_0000_0000_0000};
    localparam logic        DIR_S [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        logic acc;
        int   nacc;

        // Reset state (asynchronous, before any clock edge)
        #3;
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_busy", busy32, 1'b0);
        chk("rst_out_y", out_y32, 64'h0);
        chk("rst_out_tag", out_tag32, 5'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset_w16", in_ready16, 1'b1);
        chk("in_ready_after_reset_w32", in_ready32, 1'b1);
        chk("in_ready_after_reset_w64", in_ready64, 1'b1);

        // Unsigned max with exact latency
        drive(1'b1, '1, '1, 1'b0, 5'd3, acc);
        chk("max_accepted", acc, 1'b1);
        @(negedge clk);
        chk("latency_edge1_valid", out_valid32, 1'b0);
        @(negedge clk);
        chk("latency_edge2_valid", out_valid32, 1'b0);
        @(negedge clk);
        chk("latency_edge3_valid", out_valid32, 1'b1);
        chk("max_out_y", out_y32, 64'hFFFF_FFFE_0000_0001);
        chk("max_out_tag", out_tag32, 5'd3);
        @(posedge clk);
        #1;

        // Directed signed/unsigned back-to-back and boundary operands
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, DIR_A[i], DIR_B[i], DIR_S[i], 5'(4 + i), acc);
        end
        drain();

        // Full rate, 100 random operations
        nacc = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), acc);
            if (!acc) nacc++;
        end
        chk("full_rate_rejections", nacc, 0);
        drain();

        // Backpressure: 4 offered while the consumer stalls
        out_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(nacc < 4, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), 5'(10 + nacc), acc);
            if (acc) nacc++;
        end
        chk("backpressure_accepted", nacc, 3);
        chk("backpressure_in_ready_w16", in_ready16, 1'b0);
        chk("backpressure_in_ready_w32", in_ready32, 1'b0);
        chk("backpressure_in_ready_w64", in_ready64, 1'b0);
        drain();

        // Flush with three operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 5'(20 + i), acc);
        end
        flush = 1'b1;
        drive(1'b1, 64'd7, 64'd9, 1'b0, 5'd23, acc);
        flush = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid32, 1'b0);
        chk("flush_busy", busy32, 1'b0);
        @(posedge clk);
        #1;

        // Flush on an idle pipeline must still refuse the input
        flush = 1'b1;
        drive(1'b1, 64'd5, 64'd6, 1'b0, 5'd24, acc);
        flush = 1'b0;
        chk("flush_input_refused", acc, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_idle_busy", busy32, 1'b0);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd1234567, 1'b1, 5'd25, acc);
        chk("post_flush_accepted", acc, 1'b1);
        drain();

        // Asynchronous reset between edges with work in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 5'(26 + i), acc);
        end
        @(negedge clk);
        chk("pre_reset_out_valid", out_valid32, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid32, 1'b0);
        chk("async_reset_busy", busy32, 1'b0);
        chk("async_reset_out_tag", out_tag32, 5'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 64'h0000_0000_0001_0003, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd29, acc);
        chk("post_reset_accepted", acc, 1'b1);
        drain();

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), acc);
        end
        rand_bp = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
